// File: rtl/icache_dm_pkg.sv
// Shared bus widths and refill FSM encoding for the direct-mapped instruction cache.
package icache_dm_pkg;

  localparam int CacheAddrBus = 25;
  localparam int CacheDataBus = 32;
  localparam int CacheByteBus = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MREQ  = 2'd1,
    S_MWAIT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one write port, one read port with a registered read.
module icache_data_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with critical-word capture and
// a line refill issued one word at a time in ascending order.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CacheAddrBus-1:0] i_p_addr,
  input  logic                    i_p_read,
  input  logic                    i_p_write,
  input  logic [CacheByteBus-1:0] i_p_byte_en,
  input  logic [CacheDataBus-1:0] i_p_writedata,
  output logic [CacheDataBus-1:0] o_p_readdata,
  output logic                    o_p_readdata_valid,
  output logic                    o_p_waitrequest,
  output logic [CacheAddrBus-1:0] o_m_addr,
  output logic                    o_m_read,
  input  logic [CacheDataBus-1:0] i_m_readdata,
  input  logic                    i_m_readdata_valid,
  input  logic                    i_m_waitrequest,
  input  logic                    i_flush
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = CacheAddrBus - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e                  state_q;
  logic [OFF_W-1:0]        beat_q, lat_off_q;
  logic [IDX_W-1:0]        lat_idx_q;
  logic [TAG_W-1:0]        lat_tag_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [TAG_W-1:0]        tag_q [NUM_LINES];
  logic                    m_read_q, rvalid_q, hit_q, wait_q, flush_pend_q;
  logic [CacheAddrBus-1:0] m_addr_q;
  logic [CacheDataBus-1:0] rdata_q, cap_q, ram_rdata;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_ok, hit, miss, fill_we;
  logic             unused_ok;

  assign req_off   = i_p_addr[OFF_W-1:0];
  assign req_idx   = i_p_addr[OFF_W +: IDX_W];
  assign req_tag   = i_p_addr[CacheAddrBus-1 -: TAG_W];
  assign req_ok    = (state_q == S_IDLE) && i_p_read && !i_p_write;
  // A flush in the same cycle as a request forces the request down the miss path.
  assign hit       = req_ok && !i_flush && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss      = req_ok && !hit;
  assign fill_we   = (state_q == S_MWAIT) && i_m_readdata_valid;
  assign unused_ok = ^{i_p_byte_en, i_p_writedata};

  icache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .ADDR_W(IDX_W + OFF_W),
    .DATA_W(CacheDataBus)
  ) u_data_ram (
    .clk    (clk),
    .we_i   (fill_we),
    .waddr_i({lat_idx_q, beat_q}),
    .wdata_i(i_m_readdata),
    .raddr_i({req_idx, req_off}),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      lat_off_q    <= '0;
      lat_idx_q    <= '0;
      lat_tag_q    <= '0;
      valid_q      <= '0;
      m_read_q     <= 1'b0;
      m_addr_q     <= '0;
      rvalid_q     <= 1'b0;
      hit_q        <= 1'b0;
      wait_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
      cap_q        <= '0;
    end else begin
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
      // Freeze the RAM word presented on a hit so the output holds afterwards.
      if (hit_q) rdata_q <= ram_rdata;
      if (i_flush) valid_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            rvalid_q <= 1'b1;
            hit_q    <= 1'b1;
          end else if (miss) begin
            lat_off_q    <= req_off;
            lat_idx_q    <= req_idx;
            lat_tag_q    <= req_tag;
            beat_q       <= '0;
            m_read_q     <= 1'b1;
            m_addr_q     <= {req_tag, req_idx, OFF_W'(0)};
            wait_q       <= 1'b1;
            flush_pend_q <= 1'b0;
            state_q      <= S_MREQ;
          end
        end
        S_MREQ: begin
          if (i_flush) flush_pend_q <= 1'b1;
          if (!i_m_waitrequest) begin
            m_read_q <= 1'b0;
            state_q  <= S_MWAIT;
          end
        end
        S_MWAIT: begin
          if (i_flush) flush_pend_q <= 1'b1;
          if (i_m_readdata_valid) begin
            if (beat_q == lat_off_q) cap_q <= i_m_readdata;
            if (beat_q == LAST_BEAT) begin
              state_q <= S_DONE;
            end else begin
              beat_q   <= beat_q + OFF_W'(1);
              m_read_q <= 1'b1;
              m_addr_q <= {lat_tag_q, lat_idx_q, beat_q + OFF_W'(1)};
              state_q  <= S_MREQ;
            end
          end
        end
        S_DONE: begin
          if (!flush_pend_q && !i_flush) valid_q[lat_idx_q] <= 1'b1;
          rvalid_q     <= 1'b1;
          rdata_q      <= cap_q;
          wait_q       <= 1'b0;
          flush_pend_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_DONE) tag_q[lat_idx_q] <= lat_tag_q;
  end

  assign o_p_readdata       = hit_q ? ram_rdata : rdata_q;
  assign o_p_readdata_valid = rvalid_q;
  assign o_p_waitrequest    = wait_q;
  assign o_m_addr           = m_addr_q;
  assign o_m_read           = m_read_q;

endmodule
